// File: rtl/icache_ctrl_pkg.sv
// icache_ctrl_pkg: shared types and defaults for the instruction-memory
// sequencer.
//   - state_e    : controller state with its fixed 2-bit encoding, which is
//                  visible on state_o.
//   - *_DEF      : default address/data widths and the halt encoding.
package icache_ctrl_pkg;

  localparam int          ADDR_W_DEF    = 6;
  localparam int          DATA_W_DEF    = 32;
  localparam logic [31:0] HALT_INST_DEF = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_HALT = 2'd3
  } state_e;

endpackage

// File: rtl/icache_pc_seq.sv
// icache_pc_seq: program-counter register and its next-PC mux.
//   clk_i, rst_i      : clock and synchronous active-high reset (pc -> 0)
//   clear_i           : load pc=0 (entry into RUN)
//   run_i             : controller is in RUN; outside RUN the pc holds
//   hold_i            : stall or halt word this cycle; pc holds
//   branch_i          : take branch_target_i instead of pc+1
//   branch_target_i   : redirect address
//   pc_o              : current program counter
module icache_pc_seq #(
  parameter int ADDR_W = 6
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_i,
  input  logic              run_i,
  input  logic              hold_i,
  input  logic              branch_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  output logic [ADDR_W-1:0] pc_o
);

  logic [ADDR_W-1:0] pc_q, pc_d;

  always_comb begin
    pc_d = pc_q;
    if (clear_i)
      pc_d = '0;
    else if (run_i && !hold_i)
      // Increment wraps naturally at the address width (63 -> 0).
      pc_d = branch_i ? branch_target_i : pc_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) pc_q <= '0;
    else       pc_q <= pc_d;
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/icache_ctrl.sv
// icache_ctrl: arbitrates the 64x32 instruction memory between the program
// loader (writes) and instruction fetch (asynchronous reads), owns the PC and
// stops fetch when the halt word is read.
//   clk_i, rst_i                 : clock, synchronous active-high reset
//   load_valid_i/data_i/last_i   : loader stream; load_ready_o accepts it
//   wren_o, wraddr_o, wrdata_o   : memory write port
//   rdaddr_o, inst_i             : memory read port (same-cycle data)
//   start_i                      : begin execution at address 0
//   stall_i, branch_i, branch_target_i : PC control from the core
//   inst_o, inst_valid_o         : fetched word and its executable flag
//   pc_o, state_o, halted_o      : status
//   retired_o                    : retired-instruction count
// Optional feature: define ICACHE_CTRL_PERF_EN to build the saturating
// retired-instruction counter; otherwise retired_o is constant 0.
module icache_ctrl
  import icache_ctrl_pkg::*;
#(
  parameter int                ADDR_W    = ADDR_W_DEF,
  parameter int                DATA_W    = DATA_W_DEF,
  parameter logic [DATA_W-1:0] HALT_INST = DATA_W'(HALT_INST_DEF)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_valid_i,
  input  logic [DATA_W-1:0] load_data_i,
  input  logic              load_last_i,
  output logic              load_ready_o,
  output logic              wren_o,
  output logic [ADDR_W-1:0] wraddr_o,
  output logic [DATA_W-1:0] wrdata_o,
  output logic [ADDR_W-1:0] rdaddr_o,
  input  logic [DATA_W-1:0] inst_i,
  input  logic              start_i,
  input  logic              stall_i,
  input  logic              branch_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  output logic [DATA_W-1:0] inst_o,
  output logic              inst_valid_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic [1:0]        state_o,
  output logic              halted_o,
  output logic [15:0]       retired_o
);

  localparam logic [ADDR_W-1:0] PTR_LAST = '1;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              start_run;
  logic              load_hs;
  logic              is_halt;
  logic [ADDR_W-1:0] pc;

  assign is_halt      = (inst_i == HALT_INST);
  assign load_ready_o = (state_q != ST_RUN);
  assign load_hs      = load_valid_i & load_ready_o;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    start_run = 1'b0;
    if (load_hs) begin
      // The top address is a forced last word: never wrap onto address 0.
      if (load_last_i || ptr_q == PTR_LAST) begin
        state_d = ST_IDLE;
        ptr_d   = '0;
      end else begin
        state_d = ST_LOAD;
        ptr_d   = ptr_q + 1'b1;
      end
    end else begin
      unique case (state_q)
        ST_IDLE, ST_HALT: if (start_i) begin
          state_d   = ST_RUN;
          start_run = 1'b1;
        end
        ST_RUN: if (!stall_i && is_halt) state_d = ST_HALT;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  icache_pc_seq #(.ADDR_W(ADDR_W)) u_pc_seq (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .clear_i         (start_run),
    .run_i           (state_q == ST_RUN),
    .hold_i          (stall_i | is_halt),
    .branch_i        (branch_i),
    .branch_target_i (branch_target_i),
    .pc_o            (pc)
  );

  assign wren_o       = load_hs;
  assign wraddr_o     = ptr_q;
  assign wrdata_o     = load_data_i;
  assign rdaddr_o     = pc;
  assign pc_o         = pc;
  assign inst_o       = inst_i;
  assign inst_valid_o = (state_q == ST_RUN) && !stall_i && !is_halt;
  assign state_o      = state_q;
  assign halted_o     = (state_q == ST_HALT);

`ifdef ICACHE_CTRL_PERF_EN
  logic [15:0] retired_q, retired_d;

  always_comb begin
    retired_d = retired_q;
    if (start_run)
      retired_d = '0;
    else if (inst_valid_o && retired_q != 16'hFFFF)
      retired_d = retired_q + 16'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) retired_q <= '0;
    else       retired_q <= retired_d;
  end

  assign retired_o = retired_q;
`else
  assign retired_o = '0;
`endif

endmodule

// File: doc/icache_ctrl.md
# icache_ctrl

Sequencer and port arbiter for the 64×32 instruction memory. Shares the memory between a program loader (write side) and instruction fetch (read side), and owns the program counter. Sits between the instruction memory and the single-cycle core: it drives the memory read address and forwards the fetched word to the core with a valid flag. It also stops fetch on a halt word.

## Interface
Parameters:
- ADDR_W, 6, instruction-memory address width (64 words)
- DATA_W, 32, instruction width
- HALT_INST, 32'hFFFF_FFFF, encoding that stops fetch

Ports:
- clk_i  in  1  sole clock, rising edge
- rst_i  in  1  synchronous reset, active-high
- load_valid_i  in  1  loader word available
- load_data_i  in  DATA_W  loader word
- load_last_i  in  1  current loader word is the final word
- load_ready_o  out  1  controller accepts loader words
- wren_o  out  1  memory write enable
- wraddr_o  out  ADDR_W  memory write address
- wrdata_o  out  DATA_W  memory write data
- rdaddr_o  out  ADDR_W  memory read address (asynchronous read)
- inst_i  in  DATA_W  word returned by the memory for rdaddr_o
- start_i  in  1  begin execution at address 0
- stall_i  in  1  core holds the PC
- branch_i  in  1  redirect fetch
- branch_target_i  in  ADDR_W  redirect address
- inst_o  out  DATA_W  instruction to the core (= inst_i)
- inst_valid_o  out  1  inst_o is executable this cycle
- pc_o  out  ADDR_W  current PC (= rdaddr_o)
- state_o  out  2  IDLE=0, LOAD=1, RUN=2, HALT=3
- halted_o  out  1  state is HALT
- retired_o  out  16  retired-instruction count (see Configuration)

## Operation
States:
- IDLE (reset state)
  - load_valid_i → LOAD; the first word is written at address 0.
  - Otherwise start_i → RUN with pc=0.
  - load_valid_i has priority over start_i.
- LOAD
  - Each handshake (load_valid_i & load_ready_o) writes load_data_i at ptr, then ptr increments.
  - Handshake with load_last_i → IDLE with ptr=0.
  - A handshake at ptr=63 is a forced last: the word is written, the state goes to IDLE and ptr returns to 0. There is no wrap and no overwrite of address 0.
- RUN
  - rdaddr_o=pc.
  - inst_valid_o=1 unless stall_i=1 or inst_i==HALT_INST.
  - Next PC: stall_i → hold; else branch_i → branch_target_i; else pc+1 mod 64 (63→0).
  - stall_i wins over branch_i.
  - inst_i==HALT_INST with stall_i=0 → HALT; the PC holds.
- HALT
  - inst_valid_o=0.
  - load_valid_i → LOAD (reload from ptr=0).
  - Otherwise start_i → RUN with pc=0.

Combinational outputs:
- load_ready_o=1 in IDLE, LOAD and HALT; 0 in RUN.
- wren_o = load_valid_i & load_ready_o.
- wraddr_o=ptr; wrdata_o=load_data_i.
- A loader word offered during RUN is neither written nor dropped; it waits.

Reset:
- state=IDLE, pc=0, ptr=0, inst_valid_o=0, halted_o=0, retired_o=0, state_o=0.
- Memory contents are not cleared.
- Reset mid-LOAD or mid-RUN abandons the operation; already-written words remain.

## Timing
- Asynchronous-read memory: inst_o and inst_valid_o settle in the same cycle as pc_o.
- start_i high in cycle N (IDLE/HALT, no load_valid_i) → cycle N+1: state RUN, pc_o=0, inst_valid_o=1 (if word 0 is not a halt word).
- branch_i in cycle N with stall_i=0 → pc_o=branch_target_i in N+1.
- Halt word at cycle N → halted_o=1 at N+1.
- Load throughput: one word per cycle; wren_o is asserted in the handshake cycle itself.

## Configuration
- ICACHE_CTRL_PERF_EN defined:
  - retired_o increments on every cycle with inst_valid_o=1.
  - Saturates at 16'hFFFF.
  - Cleared by reset and on every RUN entry.
- Not defined: retired_o is tied to 0 and no counter is synthesized.

## Structure
- Package icache_ctrl_pkg holds:
  - State enum (IDLE, LOAD, RUN, HALT) and its 2-bit encoding.
  - ADDR_W and DATA_W defaults.
  - HALT_INST default.
- Sub-module icache_pc_seq holds the PC register and its next-PC mux (stall/branch/increment, start clear).
- The FSM, load pointer and counter live in icache_ctrl.

## Test plan
- Load 4 words A,B,C,HALT with load_last_i on the 4th → wren_o at addresses 0–3 in 4 consecutive cycles; state returns to IDLE.
- start_i after the load → pc_o 0,1,2,3 over four cycles; inst_valid_o 1,1,1,0; halted_o=1 in the fifth cycle.
- In RUN at pc=5: branch_i=1, target=20 → pc_o=20 next cycle. Repeat with stall_i=1 and branch_i=1 → pc stays 5 and inst_valid_o=0.
- Load 64 words without load_last_i → the 64th word is written at address 63, the state returns to IDLE, and no write occurs to address 0 after the first.
- Memory without a halt word, RUN from pc=63 → pc_o=0 next cycle. Assert rst_i mid-RUN → next cycle IDLE, pc_o=0, inst_valid_o=0.
- With ICACHE_CTRL_PERF_EN: 10 unstalled instructions then a halt → retired_o=10. Without the macro → retired_o=0.
